march_sequencer: RTL and testbench
==================================

# march_sequencer

March C- sequencer for the BIST SRAM datapath. On `start` it walks every SRAM address through the six March C- elements, driving chip-select, read/write, address and write data one operation per clock. It compares each read one cycle later against the expected background and records pass/fail, first-failure location and a saturating error count. It sits between the BIST top-level control and the SRAM/comparator datapath, replacing hand-driven `csin`/`rwbarin`/`address`/`datain` stimulus.

## Interface
- `size`, default 6: address width; depth N = 2^size.
- `length`, default 8: data width.
- `clk`  input  1: clock, rising-edge.
- `rst`  input  1: reset, asynchronous, active-low.
- `start`  input  1: begin test; sampled in IDLE and DONE only.
- `rdata`  input  length: SRAM read data, registered read, valid the cycle after a read is issued.
- `cs`  output  1: SRAM chip select.
- `rwbar`  output  1: 1 = read, 0 = write.
- `addr`  output  size: SRAM address.
- `wdata`  output  length: write data, all-0s or all-1s.
- `busy`  output  1: test in progress (RUN or DRAIN).
- `done`  output  1: test complete, held in DONE.
- `fail`  output  1: sticky; at least one mismatch this run.
- `fail_addr`  output  size: address of the first mismatch.
- `fail_elem`  output  3: March element (0–5) of the first mismatch.
- `fail_count`  output  8: mismatch count, saturates at 255.

## Operation
- States:
  - IDLE: `start` moves to RUN.
  - RUN: after the last op, moves to DRAIN.
  - DRAIN: moves to DONE after one cycle.
  - DONE: `start` moves to RUN.
  - `start` is ignored in RUN and DRAIN.
- Entering RUN clears `fail`, `fail_addr`, `fail_elem` and `fail_count`, and sets element = 0, op = 0, address = 0.
- Elements, with the address order for each:
  - E0 ⇕ (w0), ascending.
  - E1 ⇑ (r0, w1).
  - E2 ⇑ (r1, w0).
  - E3 ⇓ (r0, w1), starting at N-1.
  - E4 ⇓ (r1, w0), starting at N-1.
  - E5 ⇕ (r0), ascending.
- Data background: "0" = {length{1'b0}}, "1" = {length{1'b1}}.
- In two-op elements, the read and the write to the same address are issued on consecutive cycles; the address advances after the write.
- Element change has no bubble: the last op of Ek is followed directly by the first op of Ek+1.
- Total issue cycles = 10N (640 for size=6).
- Compare pipeline:
  - Each read registers its expected value, address and element into a compare stage.
  - The next cycle, `rdata` ≠ expected is a mismatch.
  - A mismatch sets `fail` and increments `fail_count` (saturating at 255).
  - On the first mismatch of a run only, it also loads `fail_addr` and `fail_elem`.
- Write ops are never compared.
- In IDLE, DRAIN and DONE: `cs`=0, `rwbar`=1, `addr`/`wdata` hold their last values.
- Reset values: `cs`=0, `rwbar`=1, `addr`=0, `wdata`=0, `busy`=0, `done`=0, `fail`=0, `fail_addr`=0, `fail_elem`=0, `fail_count`=0; state IDLE.
- Reset asserted mid-run aborts immediately to the reset values; no partial results are retained.

## Timing
- All outputs are registered.
- `start` high at edge 0 (IDLE): cycle 1 drives the first op (`cs`=1, `rwbar`=0, `addr`=0, `wdata`=0); `busy`=1 from cycle 1.
- Op k (k = 1..10N) is on the bus in cycle k.
- E1 first read (addr 0, expect 0) is in cycle N+1; its compare is in cycle N+2.
- The last op (E5 r0 at N-1) is in cycle 10N; cycle 10N+1 is DRAIN (`cs`=0, `busy`=1, last compare).
- Cycle 10N+2 is DONE: `done`=1, `busy`=0, and `fail`/`fail_*` are final.
- `fail`/`fail_count` update on the edge ending the compare cycle, i.e. visible 2 cycles after the read is issued.
- `start` in DONE: `done` drops and cycle 1 of a new run follows, with the same timing as from IDLE.

## Test plan
- Reset: assert `rst`=0 with random inputs -> all outputs at reset values; IDLE held with `start`=0 for 20 cycles.
- Fault-free SRAM model (size=6, length=8), 1-cycle `start` pulse:
  - Cycle 1: w0 @0.
  - Cycle 65: r0 @0.
  - Cycle 321: r0 @63 (E3 start).
  - `done` at cycle 642; `fail`=0, `fail_count`=0.
- Address 5, bit 0 stuck-at-1 -> `fail`=1, `fail_addr`=5, `fail_elem`=1, `fail_count`=3 (r0 reads in E1, E3, E5).
- Address 63, bit 7 stuck-at-0 -> `fail_addr`=63, `fail_elem`=2, `fail_count`=2 (r1 reads in E2, E4).
- `rdata` forced constant 8'hA5 -> 320 mismatches; `fail_count`=255 (saturated), `fail_addr`=0, `fail_elem`=1.
- Control corner cases:
  - `rst` low at cycle 100: outputs reset that cycle.
  - Then restart: the fault-free run completes at cycle 642.
  - `start` held high through RUN: no restart.
  - `start` in DONE after a failing run: `fail` clears and a new run begins.

Source files
------------

// File: rtl/march_sequencer.sv
// March C- BIST sequencer: walks every SRAM address through six March elements,
// one operation per clock, and scores each read one cycle after it is issued.
module march_sequencer #(
  parameter int size   = 6,
  parameter int length = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [length-1:0] rdata,
  output logic              cs,
  output logic              rwbar,
  output logic [size-1:0]   addr,
  output logic [length-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [size-1:0]   fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        fail_count,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [size-1:0] last_addr = '1;
  localparam logic [size-1:0] one_addr  = size'(1);

  logic [1:0]        state;
  logic [2:0]        cur_elem;
  logic              cur_ph;
  logic [2:0]        next_elem;
  logic              next_ph;
  logic [size-1:0]   next_addr;
  logic              next_read;
  logic              last_op;
  logic              start_run;

  logic              cmp_valid;
  logic [length-1:0] cmp_exp;
  logic [size-1:0]   cmp_addr;
  logic [2:0]        cmp_elem;
  logic              mismatch;

  assign dbg_state = state;
  assign start_run = ((state == IDLE) || (state == DONE)) && start;
  assign last_op   = (cur_elem == 3'd5) && (addr == last_addr);
  assign mismatch  = cmp_valid && (rdata != cmp_exp);

  // Next operation derived from the one currently on the bus.
  // Phase 0 is the read and phase 1 the write of two-op elements.
  always_comb begin
    next_elem = cur_elem;
    next_ph   = 1'b0;
    next_addr = addr;
    case (cur_elem)
      3'd0: begin
        if (addr == last_addr) begin
          next_elem = 3'd1;
          next_addr = '0;
        end else begin
          next_addr = addr + one_addr;
        end
      end
      3'd1, 3'd2: begin
        if (!cur_ph) begin
          next_ph = 1'b1;
        end else if (addr == last_addr) begin
          next_elem = cur_elem + 3'd1;
          next_addr = (cur_elem == 3'd1) ? '0 : last_addr;
        end else begin
          next_addr = addr + one_addr;
        end
      end
      3'd3, 3'd4: begin
        if (!cur_ph) begin
          next_ph = 1'b1;
        end else if (addr == '0) begin
          next_elem = cur_elem + 3'd1;
          next_addr = (cur_elem == 3'd3) ? last_addr : '0;
        end else begin
          next_addr = addr - one_addr;
        end
      end
      default: next_addr = addr + one_addr;
    endcase
  end

  always_comb begin
    case (next_elem)
      3'd0:    next_read = 1'b0;
      3'd5:    next_read = 1'b1;
      default: next_read = !next_ph;
    endcase
  end

  // Sequencer FSM and the registered SRAM bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cs       <= 1'b0;
      rwbar    <= 1'b1;
      addr     <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_elem <= 3'd0;
      cur_ph   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (last_op) begin
            state <= DRAIN;
            cs    <= 1'b0;
            rwbar <= 1'b1;
          end else begin
            cs       <= 1'b1;
            rwbar    <= next_read;
            addr     <= next_addr;
            cur_elem <= next_elem;
            cur_ph   <= next_ph;
            if (!next_read) begin
              wdata <= {length{(next_elem == 3'd1) || (next_elem == 3'd3)}};
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            cs       <= 1'b1;
            rwbar    <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            cur_elem <= 3'd0;
            cur_ph   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Compare stage: captures each issued read so it lines up with rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_elem  <= 3'd0;
    end else begin
      cmp_valid <= cs && rwbar;
      cmp_exp   <= {length{(cur_elem == 3'd2) || (cur_elem == 3'd4)}};
      cmp_addr  <= addr;
      cmp_elem  <= cur_elem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= 3'd0;
      fail_count <= 8'd0;
    end else if (start_run) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= 3'd0;
      fail_count <= 8'd0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (fail_count != 8'hff) begin
        fail_count <= fail_count + 8'd1;
      end
      if (!fail) begin
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
      end
    end
  end

endmodule

// File: tb/tb_march_sequencer.sv
// Directed bench for march_sequencer: behavioural SRAM with injectable read faults,
// hand-computed bus vectors and result checks.
module tb_march_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rdata;
  logic       cs, rwbar, busy, done, fail;
  logic [5:0] addr, fail_addr;
  logic [7:0] wdata, fail_count;
  logic [2:0] fail_elem;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // 0 clean, 1 addr5 bit0 stuck-1, 2 addr63 bit7 stuck-0, 3 constant A5, 4 random
  int         fault_mode = 0;
  logic [7:0] rnd_rdata  = 8'h00;
  logic [7:0] mem [64];
  logic [7:0] rd_q;
  logic [5:0] rd_a;

  logic [15:0] exp_q[$];
  int          cyc_q[$];

  march_sequencer #(.size(6), .length(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rdata(rdata),
    .cs(cs), .rwbar(rwbar), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_count(fail_count), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // SRAM model with registered read
  always @(posedge clk) begin
    if (cs && !rwbar) mem[addr] <= wdata;
    if (cs && rwbar) begin
      rd_q <= mem[addr];
      rd_a <= addr;
    end
  end

  always @* begin
    case (fault_mode)
      1:       rdata = (rd_a == 6'd5)  ? (rd_q | 8'h01) : rd_q;
      2:       rdata = (rd_a == 6'd63) ? (rd_q & 8'h7f) : rd_q;
      3:       rdata = 8'ha5;
      4:       rdata = rnd_rdata;
      default: rdata = rd_q;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  // start sampled at edge 0; returns at the negedge of cycle 1
  task automatic start_run(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 3000) step();
    check("done_cycle", cyc, 642);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    fault_mode = 4;
    repeat (4) begin
      @(negedge clk);
      start     = 1'($urandom_range(0, 1));
      rnd_rdata = 8'($urandom_range(0, 255));
    end
    #1;
    check("rst_bus", {cs, rwbar, addr, wdata}, {1'b0, 1'b1, 6'd0, 8'h00});
    check("rst_flags", {busy, done, fail}, 3'b000);
    check("rst_fail_info", {fail_addr, fail_elem, fail_count}, 17'd0);
    check("rst_state", dbg_state, 2'd0);

    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    fault_mode = 0;
    repeat (20) step();
    check("idle_hold", {cs, busy, done, dbg_state}, 5'b0);

    // clean run: bus vectors {cs, rwbar, addr, wdata}
    cyc_q = '{1, 64, 65, 66, 321, 322, 640, 641};
    exp_q = '{{1'b1, 1'b0, 6'd0,  8'h00}, {1'b1, 1'b0, 6'd63, 8'h00},
              {1'b1, 1'b1, 6'd0,  8'h00}, {1'b1, 1'b0, 6'd0,  8'hff},
              {1'b1, 1'b1, 6'd63, 8'h00}, {1'b1, 1'b0, 6'd63, 8'hff},
              {1'b1, 1'b1, 6'd63, 8'h00}, {1'b0, 1'b1, 6'd63, 8'h00}};
    start_run(1'b0);
    check("busy_c1", busy, 1'b1);
    while (exp_q.size() > 0) begin
      step_to(cyc_q.pop_front());
      check($sformatf("bus_c%0d", cyc), {cs, rwbar, addr, wdata}, exp_q.pop_front());
    end
    check("drain_flags", {busy, done}, 2'b10);
    wait_done();
    check("clean_flags", {busy, done, fail}, 3'b010);
    check("clean_count", fail_count, 8'd0);
    check("done_state", dbg_state, 2'd3);

    // addr 5 bit 0 stuck-1: first E1 read of addr 5 issued in cycle 75
    fault_mode = 1;
    start_run(1'b0);
    step_to(76);
    check("sa1_fail_c76", fail, 1'b0);
    step_to(77);
    check("sa1_fail_c77", {fail, fail_count}, {1'b1, 8'd1});
    wait_done();
    check("sa1_result", {fail, fail_addr, fail_elem, fail_count}, {1'b1, 6'd5, 3'd1, 8'd3});

    // addr 63 bit 7 stuck-0
    fault_mode = 2;
    start_run(1'b0);
    wait_done();
    check("sa0_result", {fail, fail_addr, fail_elem, fail_count}, {1'b1, 6'd63, 3'd2, 8'd2});

    // every read wrong: count saturates
    fault_mode = 3;
    start_run(1'b0);
    wait_done();
    check("sat_result", {fail, fail_addr, fail_elem, fail_count}, {1'b1, 6'd0, 3'd1, 8'd255});

    // restart from DONE after failing run, then reset mid-run
    fault_mode = 1;
    start_run(1'b0);
    check("restart_c1", {cs, done, fail, fail_count}, {1'b1, 1'b0, 1'b0, 8'd0});
    step_to(100);
    check("pre_rst_fail", fail, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_bus", {cs, rwbar, addr, busy, dbg_state}, {1'b0, 1'b1, 6'd0, 1'b0, 2'd0});
    check("midrst_fail", {fail, fail_addr, fail_count}, 15'd0);
    @(negedge clk);
    rst = 1'b1;
    fault_mode = 0;
    start_run(1'b0);
    wait_done();
    check("post_rst_clean", {fail, fail_count}, 9'd0);

    // start held high through RUN is ignored
    start_run(1'b1);
    step_to(6);
    check("held_c6", {rwbar, addr}, {1'b0, 6'd5});
    step_to(600);
    check("held_c600", {busy, cs}, 2'b11);
    start = 1'b0;
    wait_done();
    check("held_result", {fail, fail_count}, 9'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
